gray_to_bin_stream: RTL

- Streaming Gray-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray encoder.
- Accepts one W-bit Gray word per valid/ready handshake and presents the registered binary value one cycle later.
- Used where Gray-coded counters or pointers, such as encoder outputs or CDC FIFO pointers, are converted back to binary for arithmetic.
- Optionally checks that consecutive accepted codes differ in at most one bit.

---
 rtl/gray_to_bin_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/gray_to_bin_stream.sv
// Streaming Gray-to-binary decoder with a single registered output stage.
// Optional consecutive-code step checker enabled by GRAY_STEP_CHECK_EN.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   in_valid   - gray_in holds a valid word
//   in_ready   - block can accept a word this cycle
//   gray_in    - Gray-coded input word (W bits)
//   out_valid  - bin_out holds a valid word
//   out_ready  - downstream accepts bin_out this cycle
//   bin_out    - decoded binary word (registered, W bits)
//   step_err   - (GRAY_STEP_CHECK_EN only) per-word step-violation flag
//   err_sticky - (GRAY_STEP_CHECK_EN only) sticky OR of all violations

module gray_to_bin_stream #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] gray_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] bin_out
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic         step_err,
    output logic         err_sticky
`endif
);

    logic         out_valid_q;
    logic         out_valid_d;
    logic [W-1:0] bin_q;
    logic [W-1:0] bin_d;
    logic         accept;
    logic         drain;

    // The output register can take a new word whenever it is empty or
    // being emptied in this same cycle, which gives bubble-free throughput.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_d = '0;
        bin_d[W-1] = gray_in[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_d[i] = bin_d[i+1] ^ gray_in[i];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bin_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                bin_q <= bin_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;

`ifdef GRAY_STEP_CHECK_EN
    logic [W-1:0] prev_gray_q;
    logic         first_seen_q;
    logic         step_err_q;
    logic         err_sticky_q;
    logic [W-1:0] diff;
    logic         multi_bit;
    logic         viol;

    // More than one bit set <=> clearing the lowest set bit leaves a
    // nonzero value. Repeats (no change) and single-bit steps are legal.
    assign diff      = gray_in ^ prev_gray_q;
    assign multi_bit = |(diff & (diff - {{(W-1){1'b0}}, 1'b1}));
    assign viol      = first_seen_q && multi_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q  <= '0;
            first_seen_q <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (accept) begin
            prev_gray_q  <= gray_in;
            first_seen_q <= 1'b1;
            step_err_q   <= viol;
            err_sticky_q <= err_sticky_q || viol;
        end
    end

    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
`endif

endmodule
